// File: rtl/main_memory_burst.sv
// Main-memory model with a line burst engine on the L2 memory-side port.
// Optional macro MEM_CRITICAL_WORD_FIRST_EN: burst starts at addr_MEM[5:3] and wraps.
module main_memory_burst #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 64,
    parameter int BURST_LENGTH   = 8,
    parameter int MEM_DEPTH_LOG2 = 12,
    parameter int ACCESS_LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req,
    input  logic                  we_MEM,
    input  logic [ADDR_WIDTH-1:0] addr_MEM,
    inout  wire  [DATA_WIDTH-1:0] data_MEM,
    output logic                  stb,
    output logic                  busy
);
    localparam int KW       = $clog2(BURST_LENGTH);
    localparam int LINE_LSB = 3 + KW;
    localparam int LINE_W   = MEM_DEPTH_LOG2 - KW;
    localparam int LAT_W    = (ACCESS_LATENCY > 1) ? $clog2(ACCESS_LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, BEAT_A, BEAT_B} state_t;

    state_t                    state;
    state_t                    next_state;
    logic [DATA_WIDTH-1:0]     mem [0:(1<<MEM_DEPTH_LOG2)-1];
    logic                      read_q;
    logic [LINE_W-1:0]         line_q;
    logic [KW-1:0]             beat_idx;
    logic [KW-1:0]             beat_cnt;
    logic [KW-1:0]             start_beat;
    logic [LAT_W-1:0]          lat_cnt;
    logic [DATA_WIDTH-1:0]     data_q;
    logic                      drive_en;
    logic                      accept;
    logic                      load_beat;
    logic                      beat_done;
    logic                      last_beat;
    logic [MEM_DEPTH_LOG2-1:0] word_addr;
    logic                      unused_addr_bits;

    assign word_addr = {line_q, beat_idx};
    assign last_beat = (beat_cnt == KW'(BURST_LENGTH - 1));
    assign busy      = (state != IDLE);
    assign data_MEM  = drive_en ? data_q : {DATA_WIDTH{1'bz}};

`ifdef MEM_CRITICAL_WORD_FIRST_EN
    assign start_beat = addr_MEM[LINE_LSB-1:3];
`else
    assign start_beat = '0;
`endif

    // Bits above the stored depth alias; byte offset within a word is never used.
    assign unused_addr_bits = ^{addr_MEM[ADDR_WIDTH-1:MEM_DEPTH_LOG2+3], addr_MEM[LINE_LSB-1:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        load_beat  = 1'b0;
        beat_done  = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    accept     = 1'b1;
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (lat_cnt == '0) begin
                    next_state = BEAT_A;
                end
            end
            BEAT_A: begin
                load_beat  = 1'b1;
                next_state = BEAT_B;
            end
            BEAT_B: begin
                beat_done  = 1'b1;
                next_state = last_beat ? IDLE : BEAT_A;
            end
            default: next_state = IDLE;
        endcase
    end

    // Read data is captured leaving BEAT_A so it straddles the following stb edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stb      <= 1'b0;
            drive_en <= 1'b0;
            read_q   <= 1'b0;
            line_q   <= '0;
            beat_idx <= '0;
            beat_cnt <= '0;
            lat_cnt  <= '0;
            data_q   <= '0;
        end else begin
            if (accept) begin
                read_q   <= we_MEM;
                line_q   <= addr_MEM[MEM_DEPTH_LOG2+2:LINE_LSB];
                beat_idx <= start_beat;
                beat_cnt <= '0;
                lat_cnt  <= LAT_W'(ACCESS_LATENCY - 1);
            end
            if (state == WAIT && lat_cnt != '0) begin
                lat_cnt <= lat_cnt - 1'b1;
            end
            if (load_beat && read_q) begin
                data_q   <= mem[word_addr];
                drive_en <= 1'b1;
            end
            if (beat_done) begin
                stb      <= ~stb;
                beat_idx <= beat_idx + 1'b1;
                beat_cnt <= beat_cnt + 1'b1;
                if (last_beat) begin
                    drive_en <= 1'b0;
                end
            end
        end
    end

    // Storage has no reset so a mid-burst reset keeps whatever was already written.
    always_ff @(posedge clk) begin
        if (beat_done && !read_q) begin
            mem[word_addr] <= data_MEM;
        end
    end

endmodule

// File: tb/tb_main_memory_burst.sv
// Self-checking bench for main_memory_burst: vector table, directed corner cases
// and randomized bursts checked against a flat word-array model of the memory.
module tb_main_memory_burst;
    localparam int AL           = 4;
    localparam int BL           = 8;
    localparam int DEPTH        = 4096;
    localparam int LINES        = DEPTH / BL;
    localparam int BURST_CYCLES = AL + 2 * BL;
`ifdef MEM_CRITICAL_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req;
    logic        we_MEM;
    logic [31:0] addr_MEM;
    wire  [63:0] data_MEM;
    logic        stb;
    logic        busy;
    logic        tb_drive;
    logic [63:0] tb_data;

    assign data_MEM = tb_drive ? tb_data : 64'bz;

    always #5 clk = ~clk;

    main_memory_burst dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .we_MEM   (we_MEM),
        .addr_MEM (addr_MEM),
        .data_MEM (data_MEM),
        .stb      (stb),
        .busy     (busy)
    );

    typedef struct {
        logic [31:0] addr;
        logic [63:0] exp_first;
        logic [63:0] exp_last;
    } vec_t;

    logic [63:0] model_mem [DEPTH];
    logic [63:0] wr_line [BL];
    logic [63:0] rd_beats [BL];
    int          first_toggle;
    int          busy_fall;
    int          n_toggles;
    int          hold_err;
    int          checks   = 0;
    int          failures = 0;

    function automatic int start_of(input logic [31:0] a);
        return CWF ? int'((a >> 3) % BL) : 0;
    endfunction

    function automatic int word_of(input logic [31:0] a, input int off);
        return int'((a >> 6) % LINES) * BL + off;
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // An undriven bus reads as all-Z on 4-state simulators and as zero on 2-state ones.
    task automatic check_bus_released(input string name);
        checks++;
        if (!((data_MEM === 64'bz) || (data_MEM === 64'b0))) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=high-Z", name, data_MEM);
        end
    endtask

    task automatic apply_stimulus(input logic is_read, input logic [31:0] addr,
                                  input int stray_at, input int reset_after);
        logic        prev_stb;
        logic [63:0] prev_data;
        int          s;
        s = start_of(addr);
        @(negedge clk);
        req      = 1'b1;
        we_MEM   = is_read;
        addr_MEM = addr;
        if (!is_read) begin
            tb_drive = 1'b1;
            tb_data  = wr_line[s];
        end
        @(posedge clk);
        #1;
        req          = 1'b0;
        we_MEM       = 1'($urandom);
        addr_MEM     = $urandom;
        prev_stb     = stb;
        prev_data    = data_MEM;
        n_toggles    = 0;
        first_toggle = -1;
        busy_fall    = -1;
        hold_err     = 0;
        for (int c = 1; c <= 100; c++) begin
            if (c == stray_at) begin
                req      = 1'b1;
                we_MEM   = ~is_read;
                addr_MEM = $urandom;
            end
            @(posedge clk);
            #1;
            req = 1'b0;
            if (stb !== prev_stb) begin
                if (first_toggle < 0) first_toggle = c;
                if (n_toggles < BL) rd_beats[n_toggles] = prev_data;
                if (is_read && busy === 1'b1 && data_MEM !== prev_data) hold_err++;
                n_toggles++;
                if (!is_read) tb_data = wr_line[(s + n_toggles) % BL];
                if (reset_after > 0 && n_toggles == reset_after) begin
                    reset_n  = 1'b0;
                    tb_drive = 1'b0;
                    break;
                end
            end
            if (busy === 1'b0) begin
                busy_fall = c;
                break;
            end
            prev_stb  = stb;
            prev_data = data_MEM;
        end
        tb_drive = 1'b0;
    endtask

    task automatic check_timing(input string name);
        check_output({name, "_first_toggle"}, 64'(first_toggle), 64'(AL + 2));
        check_output({name, "_busy_fall"}, 64'(busy_fall), 64'(BURST_CYCLES));
        check_output({name, "_toggles"}, 64'(n_toggles), 64'(BL));
        check_output({name, "_stb_end"}, 64'(stb), 64'd0);
        check_output({name, "_hold"}, 64'(hold_err), 64'd0);
    endtask

    task automatic check_line(input string name, input logic [31:0] addr);
        int s;
        s = start_of(addr);
        for (int j = 0; j < BL; j++) begin
            check_output($sformatf("%s_beat%0d", name, j), rd_beats[j],
                         model_mem[word_of(addr, (s + j) % BL)]);
        end
    endtask

    task automatic model_write(input logic [31:0] addr, input int nbeats);
        int s;
        s = start_of(addr);
        for (int j = 0; j < nbeats; j++) begin
            model_mem[word_of(addr, (s + j) % BL)] = wr_line[(s + j) % BL];
        end
    endtask

    task automatic idle_check(input string name);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check_output({name, "_busy_idle"}, 64'(busy), 64'd0);
        check_output({name, "_stb_idle"}, 64'(stb), 64'd0);
        check_bus_released({name, "_bus_idle"});
    endtask

    initial begin
        vec_t        vecs [5];
        logic [31:0] a;
        logic        rd;

        reset_n  = 1'b0;
        req      = 1'b0;
        we_MEM   = 1'b0;
        addr_MEM = '0;
        tb_drive = 1'b0;
        tb_data  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i] = {32'(2 * i + 1), 32'(2 * i)};
            dut.mem[i]   = {32'(2 * i + 1), 32'(2 * i)};
        end

        vecs[0] = '{32'h0000_0040, 64'h00000011_00000010, 64'h0000001F_0000001E};
        vecs[1] = '{32'h0000_8040, 64'h00000011_00000010, 64'h0000001F_0000001E};
        vecs[2] = '{32'h0000_0000, 64'h00000001_00000000, 64'h0000000F_0000000E};
        vecs[3] = '{32'h0000_0028,
                    CWF ? 64'h0000000B_0000000A : 64'h00000001_00000000,
                    CWF ? 64'h00000009_00000008 : 64'h0000000F_0000000E};
        vecs[4] = '{32'h0003_FFC0, 64'h00001FF1_00001FF0, 64'h00001FFF_00001FFE};

        repeat (2) @(negedge clk);
        check_output("reset_stb", 64'(stb), 64'd0);
        check_output("reset_busy", 64'(busy), 64'd0);
        check_bus_released("reset_bus");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b1, vecs[i].addr, 0, 0);
            check_timing($sformatf("vec%0d", i));
            check_output($sformatf("vec%0d_first", i), rd_beats[0], vecs[i].exp_first);
            check_output($sformatf("vec%0d_last", i), rd_beats[BL-1], vecs[i].exp_last);
            check_line($sformatf("vec%0d", i), vecs[i].addr);
            check_bus_released($sformatf("vec%0d_release", i));
        end

        for (int w = 0; w < BL; w++) wr_line[w] = {8{8'(8'hA0 + w)}};
        apply_stimulus(1'b0, 32'h0000_0080, 0, 0);
        check_timing("wr80");
        model_write(32'h0000_0080, BL);
        apply_stimulus(1'b1, 32'h0000_0080, 0, 0);
        check_line("rd80", 32'h0000_0080);
        check_output("rd80_pattern", rd_beats[0], model_mem[word_of(32'h80, start_of(32'h80))]);
        apply_stimulus(1'b1, 32'h0000_0040, 0, 0);
        check_line("rd40_neighbour", 32'h0000_0040);
        apply_stimulus(1'b1, 32'h0000_00C0, 0, 0);
        check_line("rdC0_neighbour", 32'h0000_00C0);

        apply_stimulus(1'b1, 32'h0000_0140, 8, 0);
        check_timing("stray_mid");
        check_line("stray_mid", 32'h0000_0140);
        idle_check("stray_mid");
        apply_stimulus(1'b1, 32'h0000_0180, BURST_CYCLES, 0);
        check_timing("stray_end");
        check_line("stray_end", 32'h0000_0180);
        idle_check("stray_end");

        for (int w = 0; w < BL; w++) wr_line[w] = {8{8'(8'h50 + w)}};
        apply_stimulus(1'b0, 32'h0000_0100, 0, 3);
        #1;
        check_output("rst_mid_stb", 64'(stb), 64'd0);
        check_output("rst_mid_busy", 64'(busy), 64'd0);
        check_bus_released("rst_mid_bus");
        model_write(32'h0000_0100, 3);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        apply_stimulus(1'b1, 32'h0000_0100, 0, 0);
        check_timing("rst_readback");
        check_line("rst_readback", 32'h0000_0100);
        check_output("rst_word3_old", rd_beats[(3 - start_of(32'h100) + BL) % BL],
                     64'h00000047_00000046);

        for (int t = 0; t < 16; t++) begin
            rd = 1'($urandom);
            a  = ($urandom_range(0, 7) << 6) | ($urandom_range(0, 3) << 15) | $urandom_range(0, 63);
            if (rd) begin
                apply_stimulus(1'b1, a, 0, 0);
                check_line($sformatf("rand%0d_rd", t), a);
            end else begin
                for (int w = 0; w < BL; w++) wr_line[w] = {$urandom, $urandom};
                apply_stimulus(1'b0, a, 0, 0);
                model_write(a, BL);
            end
            check_output($sformatf("rand%0d_busy_fall", t), 64'(busy_fall), 64'(BURST_CYCLES));
        end
        for (int l = 0; l < 8; l++) begin
            apply_stimulus(1'b1, 32'(l << 6), 0, 0);
            check_line($sformatf("final_line%0d", l), 32'(l << 6));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
